// File: rtl/spi_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : spi_slave_if                                                  |
// | Brief    : SPI pins plus the RAM-side frame/readback handshake            |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
interface spi_slave_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  // Seen from the SPI slave block
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  // Seen from the SPI master / RAM side driving the slave
  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : spi_slave                                                     |
// | Brief    : SPI slave front end for a single-port RAM. Decodes a command  |
// |            bit, shifts a 10-bit word, and for read-data frames returns   |
// |            one RAM byte MSB first on MISO.                               |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module spi_slave (
  input  wire         clk,
  input  wire         rst_n,
  spi_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t     state_q,        state_d;
  logic [3:0] cnt_q,          cnt_d;          // payload bits received, 0..10
  logic [9:0] shift_q,        shift_d;
  logic [9:0] rx_data_q,      rx_data_d;
  logic       rx_valid_q,     rx_valid_d;
  logic       miso_q,         miso_d;
  logic       rd_addr_flag_q, rd_addr_flag_d; // a read address is pending
  logic [7:0] tx_byte_q,      tx_byte_d;      // captured RAM byte, shifts out MSB first
  logic [2:0] ser_cnt_q,      ser_cnt_d;
  logic       frame_done_q,   frame_done_d;   // 10 bits received and published
  logic       ser_active_q,   ser_active_d;   // MISO serialization in progress
  logic       ser_done_q,     ser_done_d;     // readback finished for this frame
  logic       armed_q,        armed_d;        // SS_n seen high since last frame start

  // Next-state and output computation; SS_n high overrides everything
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_byte_d      = tx_byte_q;
    ser_cnt_d      = ser_cnt_q;
    frame_done_d   = frame_done_q;
    ser_active_d   = ser_active_q;
    ser_done_d     = ser_done_q;
    armed_d        = armed_q;

    if (bus.SS_n) begin
      // Frame boundary: drop any partial work, keep the read-address flag
      state_d      = IDLE;
      cnt_d        = 4'd0;
      shift_d      = 10'd0;
      frame_done_d = 1'b0;
      ser_active_d = 1'b0;
      ser_done_d   = 1'b0;
      ser_cnt_d    = 3'd0;
      armed_d      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // Only start once SS_n has been seen high (e.g. after reset)
          if (armed_q) begin
            state_d = CHK_CMD;
            armed_d = 1'b0;
            cnt_d   = 4'd0;
            shift_d = 10'd0;
          end
        end

        CHK_CMD: begin
          if (!bus.MOSI)          state_d = WRITE;
          else if (rd_addr_flag_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (cnt_q != 4'd10) begin
            shift_d = {shift_q[8:0], bus.MOSI};
            cnt_d   = cnt_q + 4'd1;
          end else if (!frame_done_q) begin
            // Publish the word exactly once per frame
            frame_done_d = 1'b1;
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
          end else if (state_q == READ_DATA) begin
            if (ser_active_q) begin
              miso_d    = tx_byte_q[7];
              tx_byte_d = {tx_byte_q[6:0], 1'b0};
              ser_cnt_d = ser_cnt_q + 3'd1;
              if (ser_cnt_q == 3'd7) begin
                // Last bit launched: the pending read is now consumed
                ser_active_d   = 1'b0;
                ser_done_d     = 1'b1;
                rd_addr_flag_d = 1'b0;
              end
            end else if (!ser_done_q && bus.tx_valid) begin
              tx_byte_d    = bus.tx_data;
              ser_active_d = 1'b1;
              ser_cnt_d    = 3'd0;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      shift_q        <= 10'd0;
      rx_data_q      <= 10'd0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_byte_q      <= 8'd0;
      ser_cnt_q      <= 3'd0;
      frame_done_q   <= 1'b0;
      ser_active_q   <= 1'b0;
      ser_done_q     <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_byte_q      <= tx_byte_d;
      ser_cnt_q      <= ser_cnt_d;
      frame_done_q   <= frame_done_d;
      ser_active_q   <= ser_active_d;
      ser_done_q     <= ser_done_d;
      armed_q        <= armed_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SS_n  input  1  slave select, active-low, synchronous to clk; low marks an active frame.
REQ-005 MOSI  input  1  serial data from the master, sampled on the rising edge of clk.
REQ-006 MISO  output  1  serial read data to the master, registered.
REQ-007 rx_data  output  10  frame payload to the RAM: [9:8] is the command, [7:0] is the address or data.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  8  read data returned by the RAM.
REQ-010 tx_valid  input  1  one-cycle strobe qualifying tx_data.

Function
REQ-011 The FSM SHALL have five states: IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-012 IDLE SHALL go to CHK_CMD on the first edge that samples SS_n=0; otherwise it stays in IDLE.
REQ-013 CHK_CMD SHALL branch on the sampled MOSI bit:
- MOSI=0 -> WRITE.
- MOSI=1 and rd_addr_flag=0 -> READ_ADD.
- MOSI=1 and rd_addr_flag=1 -> READ_DATA.
REQ-014 In WRITE, READ_ADD and READ_DATA the module SHALL shift exactly 10 MOSI bits, MSB first, into a 10-bit shift register under control of a 4-bit counter.
REQ-015 On the edge after the 10th bit is sampled, rx_data SHALL take the full word and rx_valid SHALL be 1 for exactly one cycle; rx_data holds its value until the next frame completes.
REQ-016 MOSI bits after the 10th SHALL be ignored, except in the READ_DATA return phase.
REQ-017 READ_ADD completion SHALL set rd_addr_flag to 1.
REQ-018 READ_DATA completion SHALL clear rd_addr_flag to 0 once serialization finishes.
REQ-019 WRITE frames SHALL NOT change rd_addr_flag.
REQ-020 In READ_DATA after rx_valid, the module SHALL wait for tx_valid=1 and capture tx_data on that edge.
REQ-021 After the capture, MISO SHALL present tx_data[7] through tx_data[0] on 8 consecutive cycles, each bit valid from the edge after capture onward.
REQ-022 MISO SHALL be 0 at all other times.
REQ-023 tx_valid SHALL be ignored outside the READ_DATA wait phase.
REQ-024 A second tx_valid during serialization SHALL be ignored.
REQ-025 SS_n sampled high in any state SHALL force IDLE on that edge:
- partial shift content discarded, no rx_valid, MISO=0.
- rd_addr_flag unchanged, unless the READ_DATA serialization had already completed.
REQ-026 SS_n held low after the frame is complete SHALL keep the FSM in its current state with no further rx_valid.
REQ-027 A new frame SHALL start only after SS_n has been sampled high at least once.
REQ-028 If tx_valid never arrives in READ_DATA, the module SHALL wait indefinitely with MISO=0 until SS_n goes high.
REQ-029 rx_valid SHALL never be asserted in two consecutive cycles.

Reset
REQ-030 While rst_n=0, regardless of clk, the module SHALL hold:
- state=IDLE, MISO=0, rx_data=10'h000, rx_valid=0.
- rd_addr_flag=0, bit counter=0, shift register=0, captured tx byte=0.
REQ-031 An rst_n assertion mid-frame SHALL abort the frame with no rx_valid.
REQ-032 Operation SHALL resume on the first rising clk edge after rst_n is released, requiring SS_n sampled high before a new frame.

Verification
REQ-033 Write address: SS_n=0, MOSI 0 then 00_0011_0101, SS_n=1 -> one rx_valid pulse with rx_data=10'h035, MISO stays 0.
REQ-034 Write data: MOSI 0 then 01_1010_1010 -> rx_data=10'h1AA, one rx_valid, rd_addr_flag still 0.
REQ-035 Read sequence:
- READ_ADD frame 1 then 10_0011_0101 -> rx_data=10'h235, rd_addr_flag=1.
- READ_DATA frame 1 then 11_0000_0000 -> rx_data=10'h300.
- Drive tx_valid with tx_data=8'hAA one cycle later -> MISO carries 1,0,1,0,1,0,1,0 on the next 8 cycles, then rd_addr_flag=0.
REQ-036 Abort: SS_n raised after 5 payload bits of a WRITE frame -> no rx_valid, state IDLE next cycle, and the next full frame decodes correctly.
REQ-037 Reset: rst_n pulsed low during READ_DATA serialization of 8'hFF -> MISO=0 immediately, rd_addr_flag=0, and the next read frame goes to READ_ADD.
REQ-038 Stray tx_valid: tx_valid=1 with tx_data=8'h55 while in IDLE or WRITE -> MISO remains 0 and no state change.
